prbs8_checker: RTL and testbench
================================

# prbs8_checker

Receive-side checker for the 8-bit LFSR pattern source used on the board. The source steps its state as next = {s[4]^s[3]^s[2]^s[0], s[7:1]}, with 0x00 reloading to 0x01. This block takes that state stream one beat per in_valid, self-synchronises to it, and flags beats that differ from the prediction. It also keeps a saturating error count, which it can optionally show on two 7-segment digits.

## Interface
- LOCK_CNT, 4: consecutive matching beats after a seed needed to enter LOCKED (≥1).
- LOSS_CNT, 3: consecutive mismatching beats in LOCKED that force resync (≥1).
- ERR_W, 8: error counter width (≥1).
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat qualifier; in_data is sampled only when high.
- in_data  in  8  received LFSR state.
- clr_err  in  1  synchronous clear of err_cnt.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle strobe per mismatching beat while LOCKED.
- err_cnt  out  ERR_W  saturating mismatch count.
- seg0  out  7  active-low hex of err_cnt[3:0] (only with PRBS8_CHK_SEG_EN).
- seg1  out  7  active-low hex of err_cnt[7:4], zero-extended if ERR_W<8 (only with PRBS8_CHK_SEG_EN).

## Operation
- Step function: nxt(s) = (s==0) ? 0x01 : {s[4]^s[3]^s[2]^s[0], s[7:1]}.
- Registers:
  - ref: 8-bit predicted next value.
  - state: IDLE, SYNC or LOCKED.
  - run: match/miss run counter, wide enough for max(LOCK_CNT, LOSS_CNT).
- IDLE, valid beat: ref←nxt(in_data); run←0; go to SYNC.
- SYNC, valid beat:
  - in_data==ref: ref←nxt(in_data); run+1. When run+1==LOCK_CNT, go to LOCKED with run←0.
  - Otherwise reseed: ref←nxt(in_data); run←0.
- LOCKED, valid beat, match: ref←nxt(in_data); run←0.
- LOCKED, valid beat, mismatch:
  - Flywheel: ref←nxt(ref).
  - err_pulse←1; err_cnt+1, saturating at 2^ERR_W−1; run+1.
  - When run+1==LOSS_CNT: go to SYNC, ref←nxt(in_data), run←0.
- in_valid low: all state holds, err_pulse←0.
- No errors are counted in IDLE or SYNC.
- clr_err: err_cnt←0. It wins over a same-cycle increment, but err_pulse still fires for that beat.
- Reset values:
  - state IDLE; ref 0x00; run 0.
  - locked 0; err_pulse 0; err_cnt 0.
  - seg0 = seg1 = 7'b1000000 (“0”).

## Timing
- All outputs except seg0/seg1 are registered. A beat sampled at edge N is reflected after edge N.
- locked rises the cycle after the LOCK_CNT-th matching beat following the seed beat.
- locked falls the cycle after the LOSS_CNT-th consecutive miss. err_cnt includes that miss in the same cycle.
- Back-to-back beats on every cycle are supported with no bubbles.
- seg0/seg1 decode err_cnt combinationally and add zero latency.
- Asserting rst_n low mid-stream returns to IDLE immediately. The first beat after release is a seed.

## Configuration
- PRBS8_CHK_SEG_EN defined: seg0/seg1 ports and the hex decoders are present.
  - Encoding 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex of seg[6:0]).
- Not defined: the ports are absent, with no decoder logic. All other behaviour is identical.

## Structure
- Package prbs8_pkg holds:
  - the state enum (IDLE/SYNC/LOCKED);
  - the function prbs8_next(s);
  - the seed constant 8'h01;
  - the 16-entry active-low 7-seg constant table.
- One sub-module, prbs8_hex7, maps a 4-bit nibble to a 7-bit segment value. It is instantiated twice under PRBS8_CHK_SEG_EN.

## Test plan
- Lock: reset, feed 0x01,0x80,0x40,0x20,0x10 back-to-back → locked=1 after the 5th beat, err_cnt=0.
- Single error: locked, feed 0x10, then 0x89 (expected 0x88), then 0xC4 → one err_pulse, err_cnt=1, locked stays 1; 0xC4 matches via flywheel.
- Loss: locked, feed three wrong beats → err_cnt=3, locked falls after the 3rd. Four correct beats continuing from the 3rd received beat → locked=1 again.
- Zero seed: reset, feed 0x00 then 0x01,0x80,0x40,0x20 → locked=1; 0x00 predicts 0x01.
- Saturation/clear: ERR_W=2, locked, 5 errors with LOSS_CNT=8 → err_cnt stays 3. Assert clr_err on a 6th error → err_cnt=0 and err_pulse=1.
- Gaps and reset: insert random in_valid=0 gaps in the lock sequence → same result as back-to-back. Pull rst_n low mid-lock → locked=0, err_cnt=0, seg0=seg1=7'b1000000 asynchronously.

Source files
------------

// File: rtl/prbs8_pkg.sv
// Shared types, LFSR step function and 7-segment table for the PRBS8 checker.
package prbs8_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSync   = 2'd1,
    StLocked = 2'd2
  } prbs8_state_e;

  localparam logic [7:0] Prbs8Seed = 8'h01;

  // Active-low segments {g,f,e,d,c,b,a}; entry 15 first.
  localparam logic [15:0][6:0] Hex7Table = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // The all-zero state is a lock-up state of the source, which reloads the seed.
  function automatic logic [7:0] prbs8_next(input logic [7:0] s);
    if (s == 8'h00) begin
      return Prbs8Seed;
    end
    return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
  endfunction

endpackage

// File: rtl/prbs8_hex7.sv
// Nibble to active-low 7-segment decoder.
module prbs8_hex7
  import prbs8_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = Hex7Table[nibble_i];

endmodule

// File: rtl/prbs8_checker.sv
// Self-synchronising PRBS8 receive checker with saturating error count.
// Define PRBS8_CHK_SEG_EN to add the seg0/seg1 hex display outputs.
module prbs8_checker
  import prbs8_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
`ifdef PRBS8_CHK_SEG_EN
  ,
  output logic [6:0]       seg0,
  output logic [6:0]       seg1
`endif
);

  localparam int unsigned RunMax = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int unsigned RunW   = $clog2(RunMax + 1);

  prbs8_state_e     state_q, state_d;
  logic [7:0]       ref_q, ref_d;
  logic [RunW-1:0]  run_q, run_d;
  logic [RunW-1:0]  run_inc;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             match;

  assign run_inc = run_q + RunW'(1);
  assign match   = (in_data == ref_q);

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    run_d       = run_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        StIdle: begin
          ref_d   = prbs8_next(in_data);
          run_d   = '0;
          state_d = StSync;
        end
        StSync: begin
          ref_d = prbs8_next(in_data);
          if (!match) begin
            run_d = '0;
          end else if (run_inc == RunW'(LOCK_CNT)) begin
            run_d   = '0;
            state_d = StLocked;
          end else begin
            run_d = run_inc;
          end
        end
        StLocked: begin
          if (match) begin
            ref_d = prbs8_next(in_data);
            run_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            if (run_inc == RunW'(LOSS_CNT)) begin
              state_d = StSync;
              ref_d   = prbs8_next(in_data);
              run_d   = '0;
            end else begin
              // Flywheel: keep predicting from our own reference across a miss.
              ref_d = prbs8_next(ref_q);
              run_d = run_inc;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (clr_err) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ref_q       <= 8'h00;
      run_q       <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      run_q       <= run_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = (state_q == StLocked);
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

`ifdef PRBS8_CHK_SEG_EN
  logic [7:0] err_ext;
  assign err_ext = 8'(err_cnt_q);

  prbs8_hex7 u_hex0 (
    .nibble_i (err_ext[3:0]),
    .seg_o    (seg0)
  );

  prbs8_hex7 u_hex1 (
    .nibble_i (err_ext[7:4]),
    .seg_o    (seg1)
  );
`endif

endmodule

// File: tb/tb_prbs8_checker.sv
// Randomised bench for prbs8_checker; two configurations share one stimulus stream.
module tb_prbs8_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       clr_err = 1'b0;

  logic       locked0, err_pulse0;
  logic [7:0] err_cnt0;
  logic       locked1, err_pulse1;
  logic [1:0] err_cnt1;
`ifdef PRBS8_CHK_SEG_EN
  logic [6:0] seg0_0, seg1_0, seg0_1, seg1_1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  prbs8_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(8)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr_err   (clr_err),
    .locked    (locked0),
    .err_pulse (err_pulse0),
    .err_cnt   (err_cnt0)
`ifdef PRBS8_CHK_SEG_EN
    ,
    .seg0      (seg0_0),
    .seg1      (seg1_0)
`endif
  );

  prbs8_checker #(.LOCK_CNT(4), .LOSS_CNT(8), .ERR_W(2)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr_err   (clr_err),
    .locked    (locked1),
    .err_pulse (err_pulse1),
    .err_cnt   (err_cnt1)
`ifdef PRBS8_CHK_SEG_EN
    ,
    .seg0      (seg0_1),
    .seg1      (seg1_1)
`endif
  );

  // Reference model: 0 = idle, 1 = hunting, 2 = locked.
  int unsigned m_state [2];
  int unsigned m_ref   [2];
  int unsigned m_run   [2];
  int unsigned m_err   [2];
  bit          m_pulse [2];
  int unsigned lock_n  [2] = '{4, 4};
  int unsigned loss_n  [2] = '{3, 8};
  int unsigned err_max [2] = '{255, 3};
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic int unsigned nxt(input int unsigned s);
    int unsigned fb;
    if (s == 0) return 1;
    fb = ((s >> 4) ^ (s >> 3) ^ (s >> 2) ^ s) & 1;
    return (fb << 7) | (s >> 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_ref[k] = 0; m_run[k] = 0; m_err[k] = 0; m_pulse[k] = 0;
    end
  endtask

  task automatic model_beat(input int k, input bit v, input int unsigned d, input bit clr);
    m_pulse[k] = 0;
    if (v) begin
      if (m_state[k] == 0) begin
        m_ref[k] = nxt(d); m_run[k] = 0; m_state[k] = 1;
      end else if (m_state[k] == 1) begin
        if (d == m_ref[k]) begin
          m_run[k]++;
          if (m_run[k] == lock_n[k]) begin m_state[k] = 2; m_run[k] = 0; end
        end else m_run[k] = 0;
        m_ref[k] = nxt(d);
      end else if (d == m_ref[k]) begin
        m_ref[k] = nxt(d); m_run[k] = 0;
      end else begin
        m_pulse[k] = 1;
        if (m_err[k] < err_max[k]) m_err[k]++;
        m_run[k]++;
        if (m_run[k] == loss_n[k]) begin
          m_state[k] = 1; m_ref[k] = nxt(d); m_run[k] = 0;
        end else m_ref[k] = nxt(m_ref[k]);
      end
    end
    if (clr) m_err[k] = 0;
  endtask

  task automatic check_outputs();
    check_eq("locked0", locked0, m_state[0] == 2);
    check_eq("pulse0", err_pulse0, m_pulse[0]);
    check_eq("errcnt0", err_cnt0, m_err[0]);
    check_eq("locked1", locked1, m_state[1] == 2);
    check_eq("pulse1", err_pulse1, m_pulse[1]);
    check_eq("errcnt1", err_cnt1, m_err[1]);
`ifdef PRBS8_CHK_SEG_EN
    check_eq("seg0_0", seg0_0, seg_tab[m_err[0] & 15]);
    check_eq("seg1_0", seg1_0, seg_tab[(m_err[0] >> 4) & 15]);
    check_eq("seg0_1", seg0_1, seg_tab[m_err[1] & 15]);
    check_eq("seg1_1", seg1_1, 7'h40);
`endif
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit clr);
    in_valid = v; in_data = d; clr_err = clr;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_beat(k, v, d, clr);
    #1;
    check_outputs();
    in_valid = 1'b0; clr_err = 1'b0;
  endtask

  // Asserted mid-cycle: outputs must clear without waiting for a clock edge.
  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    check_eq("rst_locked", locked0, 1'b0);
    check_eq("rst_errcnt", err_cnt0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic feed_lock(input bit gaps);
    logic [7:0] seq [5];
    seq = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10};
    for (int i = 0; i < 5; i++) begin
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) step(1'b0, 8'h00, 1'b0);
      end
      step(1'b1, seq[i], 1'b0);
      if (i == 3) check_eq("lock_early", locked0, 1'b0);
    end
    check_eq("lock_done", locked0, 1'b1);
  endtask

  initial begin
    int unsigned exp_v, w, src;
    logic [7:0] d;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Lock, then a single error absorbed by the flywheel.
    feed_lock(1'b0);
    check_eq("lock_errcnt", err_cnt0, 8'd0);
    step(1'b1, 8'h89, 1'b0);
    check_eq("single_pulse", err_pulse0, 1'b1);
    check_eq("single_cnt", err_cnt0, 8'd1);
    step(1'b1, 8'hC4, 1'b0);
    check_eq("single_locked", locked0, 1'b1);
    check_eq("single_nopulse", err_pulse0, 1'b0);

    // Loss of lock after three misses, then relock from the third received beat.
    exp_v = nxt(8'hC4);
    w = 0;
    for (int i = 0; i < 3; i++) begin
      w = exp_v ^ 8'h5A;
      step(1'b1, 8'(w), 1'b0);
      exp_v = nxt(exp_v);
    end
    check_eq("loss_locked", locked0, 1'b0);
    check_eq("loss_cnt", err_cnt0, 8'd4);
    exp_v = nxt(w);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(exp_v), 1'b0);
      exp_v = nxt(exp_v);
    end
    check_eq("relock", locked0, 1'b1);

    // Zero seed predicts the reload value.
    async_reset();
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'h40, 1'b0);
    step(1'b1, 8'h20, 1'b0);
    check_eq("zero_seed_lock", locked0, 1'b1);

    // Saturation on the narrow counter, then clear racing an increment.
    exp_v = nxt(8'h20);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(exp_v ^ 8'h33), 1'b0);
      exp_v = nxt(exp_v);
    end
    check_eq("sat_cnt", err_cnt1, 2'd3);
    check_eq("sat_locked", locked1, 1'b1);
    step(1'b1, 8'(exp_v ^ 8'h33), 1'b1);
    check_eq("clr_cnt", err_cnt1, 2'd0);
    check_eq("clr_pulse", err_pulse1, 1'b1);

    // Lock with idle gaps, then reset mid-lock.
    async_reset();
    feed_lock(1'b1);
    step(1'b1, 8'h77, 1'b0);
    async_reset();

    // Random stream: gaps, corruption, clears, resyncs and resets.
    src = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      if ($urandom_range(0, 199) == 0) src = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) begin
        step(1'b0, 8'($urandom), $urandom_range(0, 49) == 0);
      end else begin
        d = 8'(src);
        if ($urandom_range(0, 9) == 0) d = 8'($urandom);
        step(1'b1, d, $urandom_range(0, 49) == 0);
        src = nxt(src);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
